// File: rtl/sramlike_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sramlike_pkg
// Brief    : Shared encodings and width helpers for the SRAM-like arbiter.
// Revision : 1.0
// ============================================================================
package sramlike_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    // Channel-ID width; a single channel still needs one bit of storage.
    function automatic int id_w(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sramlike_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sramlike_arbiter_if
// Brief    : Channel-side and slave-side SRAM-like buses of the arbiter.
// Revision : 1.0
// ============================================================================
interface sramlike_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [NUM_CH-1:0]        ch_req;
    logic [NUM_CH-1:0]        ch_wr;
    logic [2*NUM_CH-1:0]      ch_size;
    logic [ADDR_W*NUM_CH-1:0] ch_addr;
    logic [DATA_W*NUM_CH-1:0] ch_wdata;
    logic [NUM_CH-1:0]        ch_addr_ok;
    logic [NUM_CH-1:0]        ch_data_ok;
    logic [DATA_W-1:0]        ch_rdata;

    logic                     m_req;
    logic                     m_wr;
    logic [1:0]               m_size;
    logic [ADDR_W-1:0]        m_addr;
    logic [DATA_W-1:0]        m_wdata;
    logic                     m_addr_ok;
    logic                     m_data_ok;
    logic [DATA_W-1:0]        m_rdata;

    // master: the surrounding system (requesting channels plus the downstream slave).
    modport master (
        output ch_req, ch_wr, ch_size, ch_addr, ch_wdata,
        input  ch_addr_ok, ch_data_ok, ch_rdata,
        input  m_req, m_wr, m_size, m_addr, m_wdata,
        output m_addr_ok, m_data_ok, m_rdata
    );

    // slave: the arbiter itself.
    modport slave (
        input  ch_req, ch_wr, ch_size, ch_addr, ch_wdata,
        output ch_addr_ok, ch_data_ok, ch_rdata,
        output m_req, m_wr, m_size, m_addr, m_wdata,
        input  m_addr_ok, m_data_ok, m_rdata
    );
endinterface
`default_nettype wire

// File: rtl/sramlike_arbiter_id_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sramlike_id_fifo
// Brief    : In-order FIFO of channel IDs for accepted, unanswered requests.
// Revision : 1.0
// ============================================================================
module sramlike_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     push,
    input  wire logic                     pop,
    input  wire logic [WIDTH-1:0]         din,
    output logic      [WIDTH-1:0]         dout,
    output logic                          full,
    output logic                          empty,
    output logic      [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // A full FIFO refuses a push even when a pop frees a slot this cycle.
    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign dout      = r_mem[r_rd_ptr];
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sramlike_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sramlike_arbiter
// Brief    : N-channel SRAM-like arbiter onto one slave port, in-order responses.
//            Define SRAMLIKE_ARB_RR_EN for round-robin instead of fixed priority.
// Revision : 1.0
// ============================================================================
module sramlike_arbiter
    import sramlike_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int OUTST_DEPTH = 4
) (
    input  wire logic                          clk,
    input  wire logic                          rst,
    sramlike_arbiter_if.slave                  bus,
    output logic [cnt_w(OUTST_DEPTH)-1:0]      outst_cnt,
    output logic                               proto_err
);
    localparam int ID_W = id_w(NUM_CH);

    lock_state_t     r_state;
    lock_state_t     w_state_nxt;
    logic [ID_W-1:0] r_lock_id;
    logic [ID_W-1:0] w_lock_id_nxt;
    logic            r_proto_err;
    logic            w_proto_err_nxt;
    logic [ID_W-1:0] w_grant;
    logic            w_m_req;
    logic            w_accept;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [ID_W-1:0] w_head;

`ifdef SRAMLIKE_ARB_RR_EN
    logic [ID_W-1:0] r_rr_ptr;
    logic [ID_W-1:0] w_rr_ptr_nxt;
`endif

    always_comb begin
        w_grant = '0;
        if (r_state == ST_LOCKED) begin
            w_grant = r_lock_id;
        end else begin
`ifdef SRAMLIKE_ARB_RR_EN
            begin : g_rr_search
                logic found;
                int   idx;
                found = 1'b0;
                idx   = 0;
                for (int k = 0; k < NUM_CH; k++) begin
                    idx = (int'(r_rr_ptr) + k) % NUM_CH;
                    if (!found && bus.ch_req[idx]) begin
                        w_grant = ID_W'(idx);
                        found   = 1'b1;
                    end
                end
            end
`else
            // Descending scan so the lowest requesting index wins.
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                if (bus.ch_req[k]) begin
                    w_grant = ID_W'(k);
                end
            end
`endif
        end
    end

    assign w_m_req  = bus.ch_req[w_grant] & ~w_full;
    assign w_accept = w_m_req & bus.m_addr_ok;
    assign w_pop    = bus.m_data_ok & ~w_empty;

    assign bus.m_req      = w_m_req;
    assign bus.m_wr       = bus.ch_wr[w_grant];
    assign bus.m_size     = bus.ch_size[int'(w_grant)*2 +: 2];
    assign bus.m_addr     = bus.ch_addr[int'(w_grant)*ADDR_W +: ADDR_W];
    assign bus.m_wdata    = bus.ch_wdata[int'(w_grant)*DATA_W +: DATA_W];
    assign bus.ch_addr_ok = w_accept ? (NUM_CH'(1) << w_grant) : '0;
    assign bus.ch_data_ok = w_pop ? (NUM_CH'(1) << w_head) : '0;
    assign bus.ch_rdata   = bus.m_rdata;
    assign proto_err      = r_proto_err;

    sramlike_id_fifo #(
        .DEPTH (OUTST_DEPTH),
        .WIDTH (ID_W)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_accept),
        .pop   (w_pop),
        .din   (w_grant),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (outst_cnt)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_lock_id_nxt   = r_lock_id;
        w_proto_err_nxt = r_proto_err;
        // A locked master withdrawing its request before addr_ok is a violation.
        if ((r_state == ST_LOCKED) && !bus.ch_req[r_lock_id]) begin
            w_state_nxt     = ST_IDLE;
            w_proto_err_nxt = 1'b1;
        end else if (w_accept) begin
            w_state_nxt = ST_IDLE;
        end else if (w_m_req && !bus.m_addr_ok) begin
            w_state_nxt   = ST_LOCKED;
            w_lock_id_nxt = w_grant;
        end
        if (bus.m_data_ok && w_empty) begin
            w_proto_err_nxt = 1'b1;
        end
    end

`ifdef SRAMLIKE_ARB_RR_EN
    always_comb begin
        w_rr_ptr_nxt = r_rr_ptr;
        if (w_accept) begin
            w_rr_ptr_nxt = (int'(w_grant) == NUM_CH - 1) ? '0 : w_grant + ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else begin
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_lock_id   <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lock_id   <= w_lock_id_nxt;
            r_proto_err <= w_proto_err_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sramlike_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sramlike_arbiter
// Brief    : Directed vector bench for sramlike_arbiter (NUM_CH=2, depth 4).
// Revision : 1.0
// ============================================================================
module tb_sramlike_arbiter;
    import sramlike_pkg::*;

    localparam logic [31:0] c_addr0  = 32'h1000_0000;
    localparam logic [31:0] c_addr1  = 32'h2000_0004;
    localparam logic [31:0] c_wdata0 = 32'hDEAD_0000;
    localparam logic [31:0] c_wdata1 = 32'hBEEF_0001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] outst_cnt;
    logic       proto_err;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    sramlike_arbiter_if #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32)) bus ();

    sramlike_arbiter #(
        .NUM_CH      (2),
        .ADDR_W      (32),
        .DATA_W      (32),
        .OUTST_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .outst_cnt (outst_cnt),
        .proto_err (proto_err)
    );

    typedef struct {
        logic [1:0]  req;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        logic        exp_mreq;
        int          exp_ch;
        logic [1:0]  exp_aok;
        logic [1:0]  exp_dok;
        logic [2:0]  exp_cnt;
        logic        exp_err;
    } vec_t;

    vec_t vecs [24];

    function automatic vec_t mk(input logic [1:0] req, input logic aok, input logic dok,
                                input logic [31:0] rdata, input logic mreq, input int ch,
                                input logic [1:0] eaok, input logic [1:0] edok,
                                input logic [2:0] cnt, input logic err);
        vec_t v;
        v.req = req; v.aok = aok; v.dok = dok; v.rdata = rdata;
        v.exp_mreq = mreq; v.exp_ch = ch; v.exp_aok = eaok; v.exp_dok = edok;
        v.exp_cnt = cnt; v.exp_err = err;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [1:0] req, input logic aok, input logic dok, input logic [31:0] rd);
        @(posedge clk);
        #1;
        bus.ch_req    = req;
        bus.m_addr_ok = aok;
        bus.m_data_ok = dok;
        bus.m_rdata   = rd;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst           = 1'b1;
        bus.ch_req    = 2'b00;
        bus.m_addr_ok = 1'b0;
        bus.m_data_ok = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int n0;
    int n1;
    logic [1:0] exp_arb;

    initial begin
        bus.ch_req    = 2'b00;
        bus.ch_wr     = 2'b10;
        bus.ch_size   = {SZ_BYTE, SZ_WORD};
        bus.ch_addr   = {c_addr1, c_addr0};
        bus.ch_wdata  = {c_wdata1, c_wdata0};
        bus.m_addr_ok = 1'b0;
        bus.m_data_ok = 1'b0;
        bus.m_rdata   = '0;

        //               req    aok   dok   rdata          mreq ch  aok    dok    cnt  err
        vecs[0]  = mk(2'b11, 1'b1, 1'b0, 32'h0,         1'b1, 0, 2'b01, 2'b00, 3'd0, 1'b0);
        vecs[1]  = mk(2'b10, 1'b1, 1'b0, 32'h0,         1'b1, 1, 2'b10, 2'b00, 3'd1, 1'b0);
        vecs[2]  = mk(2'b00, 1'b0, 1'b1, 32'hAAAA_0000, 1'b0, 0, 2'b00, 2'b01, 3'd2, 1'b0);
        vecs[3]  = mk(2'b00, 1'b0, 1'b1, 32'hBBBB_0001, 1'b0, 0, 2'b00, 2'b10, 3'd1, 1'b0);
        vecs[4]  = mk(2'b00, 1'b0, 1'b0, 32'h0,         1'b0, 0, 2'b00, 2'b00, 3'd0, 1'b0);
        vecs[5]  = mk(2'b10, 1'b0, 1'b0, 32'h0,         1'b1, 1, 2'b00, 2'b00, 3'd0, 1'b0);
        vecs[6]  = mk(2'b11, 1'b0, 1'b0, 32'h0,         1'b1, 1, 2'b00, 2'b00, 3'd0, 1'b0);
        vecs[7]  = mk(2'b11, 1'b0, 1'b0, 32'h0,         1'b1, 1, 2'b00, 2'b00, 3'd0, 1'b0);
        vecs[8]  = mk(2'b11, 1'b1, 1'b0, 32'h0,         1'b1, 1, 2'b10, 2'b00, 3'd0, 1'b0);
        vecs[9]  = mk(2'b01, 1'b1, 1'b0, 32'h0,         1'b1, 0, 2'b01, 2'b00, 3'd1, 1'b0);
        vecs[10] = mk(2'b01, 1'b1, 1'b0, 32'h0,         1'b1, 0, 2'b01, 2'b00, 3'd2, 1'b0);
        vecs[11] = mk(2'b01, 1'b1, 1'b0, 32'h0,         1'b1, 0, 2'b01, 2'b00, 3'd3, 1'b0);
        vecs[12] = mk(2'b01, 1'b1, 1'b0, 32'h0,         1'b0, 0, 2'b00, 2'b00, 3'd4, 1'b0);
        vecs[13] = mk(2'b01, 1'b1, 1'b1, 32'h0000_0011, 1'b0, 0, 2'b00, 2'b10, 3'd4, 1'b0);
        vecs[14] = mk(2'b01, 1'b1, 1'b0, 32'h0,         1'b1, 0, 2'b01, 2'b00, 3'd3, 1'b0);
        vecs[15] = mk(2'b00, 1'b0, 1'b1, 32'h0000_0022, 1'b0, 0, 2'b00, 2'b01, 3'd4, 1'b0);
        vecs[16] = mk(2'b00, 1'b0, 1'b1, 32'h0000_0023, 1'b0, 0, 2'b00, 2'b01, 3'd3, 1'b0);
        vecs[17] = mk(2'b00, 1'b0, 1'b1, 32'h0000_0024, 1'b0, 0, 2'b00, 2'b01, 3'd2, 1'b0);
        vecs[18] = mk(2'b00, 1'b0, 1'b1, 32'h0000_0025, 1'b0, 0, 2'b00, 2'b01, 3'd1, 1'b0);
        vecs[19] = mk(2'b00, 1'b0, 1'b0, 32'h0,         1'b0, 0, 2'b00, 2'b00, 3'd0, 1'b0);
        vecs[20] = mk(2'b00, 1'b0, 1'b1, 32'h0,         1'b0, 0, 2'b00, 2'b00, 3'd0, 1'b0);
        vecs[21] = mk(2'b00, 1'b0, 1'b0, 32'h0,         1'b0, 0, 2'b00, 2'b00, 3'd0, 1'b1);
        vecs[22] = mk(2'b01, 1'b1, 1'b0, 32'h0,         1'b1, 0, 2'b01, 2'b00, 3'd0, 1'b1);
        vecs[23] = mk(2'b00, 1'b0, 1'b1, 32'h0000_0033, 1'b0, 0, 2'b00, 2'b01, 3'd1, 1'b1);

        // Reset state.
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("reset m_req", 64'(bus.m_req), 64'd0);
        check("reset ch_addr_ok", 64'(bus.ch_addr_ok), 64'd0);
        check("reset ch_data_ok", 64'(bus.ch_data_ok), 64'd0);
        check("reset outst_cnt", 64'(outst_cnt), 64'd0);
        check("reset proto_err", 64'(proto_err), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            cyc(vecs[i].req, vecs[i].aok, vecs[i].dok, vecs[i].rdata);
            check($sformatf("v%0d m_req", i), 64'(bus.m_req), 64'(vecs[i].exp_mreq));
            check($sformatf("v%0d ch_addr_ok", i), 64'(bus.ch_addr_ok), 64'(vecs[i].exp_aok));
            check($sformatf("v%0d ch_data_ok", i), 64'(bus.ch_data_ok), 64'(vecs[i].exp_dok));
            check($sformatf("v%0d outst_cnt", i), 64'(outst_cnt), 64'(vecs[i].exp_cnt));
            check($sformatf("v%0d proto_err", i), 64'(proto_err), 64'(vecs[i].exp_err));
            if (vecs[i].exp_mreq) begin
                check($sformatf("v%0d m_addr", i), 64'(bus.m_addr),
                      64'((vecs[i].exp_ch == 1) ? c_addr1 : c_addr0));
                check($sformatf("v%0d m_wdata", i), 64'(bus.m_wdata),
                      64'((vecs[i].exp_ch == 1) ? c_wdata1 : c_wdata0));
                check($sformatf("v%0d m_size", i), 64'(bus.m_size),
                      64'((vecs[i].exp_ch == 1) ? SZ_BYTE : SZ_WORD));
                check($sformatf("v%0d m_wr", i), 64'(bus.m_wr), 64'(vecs[i].exp_ch == 1));
            end
            if (vecs[i].exp_dok != 2'b00) begin
                check($sformatf("v%0d ch_rdata", i), 64'(bus.ch_rdata), 64'(vecs[i].rdata));
            end
        end

        // Reset with outstanding IDs and a pending lock on channel 1.
        cyc(2'b01, 1'b1, 1'b0, 32'h0);
        cyc(2'b01, 1'b1, 1'b0, 32'h0);
        cyc(2'b01, 1'b1, 1'b0, 32'h0);
        cyc(2'b10, 1'b0, 1'b0, 32'h0);
        check("pre-rst outst_cnt", 64'(outst_cnt), 64'd3);
        @(posedge clk);
        #1;
        rst           = 1'b1;
        bus.ch_req    = 2'b11;
        bus.m_addr_ok = 1'b0;
        bus.m_data_ok = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst outst_cnt", 64'(outst_cnt), 64'd0);
        check("rst ch_data_ok", 64'(bus.ch_data_ok), 64'd0);
        check("rst proto_err", 64'(proto_err), 64'd0);
        check("rst lock cleared", 64'(bus.m_addr), 64'(c_addr0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Stray response after reset.
        cyc(2'b00, 1'b0, 1'b1, 32'h0);
        check("stray ch_data_ok", 64'(bus.ch_data_ok), 64'd0);
        cyc(2'b00, 1'b0, 1'b0, 32'h0);
        check("stray proto_err", 64'(proto_err), 64'd1);
        cyc(2'b00, 1'b0, 1'b0, 32'h0);
        check("sticky proto_err", 64'(proto_err), 64'd1);

        // Locked master withdraws its request.
        do_reset();
        cyc(2'b10, 1'b0, 1'b0, 32'h0);
        check("lock m_req", 64'(bus.m_req), 64'd1);
        cyc(2'b01, 1'b0, 1'b0, 32'h0);
        check("withdraw m_req", 64'(bus.m_req), 64'd0);
        check("withdraw proto_err", 64'(proto_err), 64'd0);
        cyc(2'b01, 1'b0, 1'b0, 32'h0);
        check("unlock m_req", 64'(bus.m_req), 64'd1);
        check("unlock m_addr", 64'(bus.m_addr), 64'(c_addr0));
        check("withdraw err set", 64'(proto_err), 64'd1);

        // Continuous contention with one push and one pop per cycle.
        do_reset();
        n0 = 0;
        n1 = 0;
        cyc(2'b11, 1'b1, 1'b0, 32'h0);
        check("arb first", 64'(bus.ch_addr_ok), 64'd1);
        if (bus.ch_addr_ok[0]) n0++;
        if (bus.ch_addr_ok[1]) n1++;
        for (int k = 0; k < 20; k++) begin
            cyc(2'b11, 1'b1, 1'b1, 32'h0);
`ifdef SRAMLIKE_ARB_RR_EN
            exp_arb = (k % 2 == 0) ? 2'b10 : 2'b01;
`else
            exp_arb = 2'b01;
`endif
            check($sformatf("arb c%0d", k), 64'(bus.ch_addr_ok), 64'(exp_arb));
            if (bus.ch_addr_ok[0]) n0++;
            if (bus.ch_addr_ok[1]) n1++;
        end
        check("arb outst_cnt", 64'(outst_cnt), 64'd1);
`ifdef SRAMLIKE_ARB_RR_EN
        check("rr fairness", 64'((n0 > n1) ? (n0 - n1) : (n1 - n0)), 64'd1);
`else
        check("fixed prio ch1 starved", 64'(n1), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sramlike_arbiter.md
Name: sramlike_arbiter

Overview:
- Parametrised N-channel arbiter joining several SRAM-like masters (instruction fetch, data, future cache-refill ports) onto one SRAM-like slave port, normally the AXI bridge.
- Sits between the mips core and the AXI interface.
- Supports multiple outstanding transactions, tracked in order by an ID FIFO.
- Read data and data_ok are routed back to the channel that issued each request.

Parameters:
- NUM_CH, 2, number of master channels; channel 0 has highest fixed priority.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- OUTST_DEPTH, 4, maximum accepted-but-unanswered transactions; power of two, ≥2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ch_req  in  NUM_CH  per-channel request
- ch_wr  in  NUM_CH  per-channel write (1) / read (0)
- ch_size  in  2*NUM_CH  per-channel size: 0 = byte, 1 = half, 2 = word
- ch_addr  in  ADDR_W*NUM_CH  per-channel address, channel i at slice i
- ch_wdata  in  DATA_W*NUM_CH  per-channel write data
- ch_addr_ok  out  NUM_CH  request accepted
- ch_data_ok  out  NUM_CH  response returned
- ch_rdata  out  DATA_W  read data, broadcast; valid for the channel whose ch_data_ok is set
- m_req  out  1  slave request
- m_wr  out  1  slave write
- m_size  out  2  slave size
- m_addr  out  ADDR_W  slave address
- m_wdata  out  DATA_W  slave write data
- m_addr_ok  in  1  slave accept
- m_data_ok  in  1  slave response
- m_rdata  in  DATA_W  slave read data
- outst_cnt  out  clog2(OUTST_DEPTH)+1  current outstanding count
- proto_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (rst=1 at a clk edge):
  - FIFO pointers, outst_cnt, lock, lock_id, rr pointer and proto_err all clear to 0.
  - Combinational outputs follow, so all ch_addr_ok, ch_data_ok and m_req are 0 while the FIFO is empty and no channel requests.
- Grant (combinational):
  - If lock=1, grant = lock_id.
  - Otherwise grant = lowest-index channel with ch_req=1.
  - m_req = ch_req[grant] & ~full.
  - m_wr, m_size, m_addr and m_wdata are muxed from the grant channel.
- Accept:
  - ch_addr_ok[grant] = m_req & m_addr_ok; all other bits are 0.
  - On accept, grant is pushed into the ID FIFO and outst_cnt is incremented.
  - Zero added latency: accept happens in the same cycle as the slave's m_addr_ok.
- Lock:
  - If m_req=1 and m_addr_ok=0, set lock=1 and lock_id=grant. The grant cannot change while the request is pending, as SRAM-like masters hold their fields until addr_ok.
  - lock clears on accept.
  - lock also clears if ch_req[lock_id] drops; this is a master protocol violation and sets proto_err.
- Full:
  - full = (outst_cnt == OUTST_DEPTH). While full, m_req=0.
  - A pop in the same cycle does not unblock the push. The next cycle is eligible.
- Response:
  - On m_data_ok with the FIFO non-empty, ch_data_ok[head]=1, ch_rdata=m_rdata, the head is popped and outst_cnt is decremented.
  - Responses are strictly in order.
  - Write responses also pulse ch_data_ok; ch_rdata is don't-care for writes.
- Simultaneous push and pop: both occur and outst_cnt is unchanged. Pushing into a slot freed in the same cycle is not permitted when full; see Full.
- Empty: m_data_ok while outst_cnt=0 is ignored (no ch_data_ok) and sets proto_err.
- proto_err clears only on rst.
- Pointer wrap: read and write pointers wrap modulo OUTST_DEPTH; the count disambiguates full from empty.
- Reset mid-operation: all outstanding IDs are discarded. A later stray m_data_ok is an empty-FIFO error.

Optional Feature:
- Macro: SRAMLIKE_ARB_RR_EN.
- Defined: unlocked grant is round-robin. Search starts at rr_ptr; after each accept, rr_ptr = grant+1 mod NUM_CH.
- Undefined: fixed priority, channel 0 highest. rr_ptr logic is absent.
- Lock semantics are identical in both cases.

Decomposition:
- Package sramlike_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - ID width function, clog2(NUM_CH) with a minimum of 1
  - count-width helper
- One sub-module, sramlike_id_fifo: parameters DEPTH and WIDTH; ports push, pop, din, dout, full, empty, count; synchronous active-high reset.
- Arbitration and mux logic stay in the top module.

Test Plan:
- NUM_CH=2. Both channels request reads the same cycle; m_addr_ok=1 → channel 0 accepted first, channel 1 the next cycle; FIFO holds {0,1}. m_data_ok with m_rdata=0xAAAA0000 then 0xBBBB0001 → ch_data_ok 01 then 10, with matching ch_rdata.
- Channel 1 requests alone and m_addr_ok is held 0 for 3 cycles. Channel 0 raises ch_req in cycle 2 → m_addr stays at channel 1's address until accept; ch_addr_ok=10.
- Issue 4 accepted requests with no responses, OUTST_DEPTH=4 → outst_cnt=4, m_req=0 on the 5th. One m_data_ok → the next cycle accepts; outst_cnt returns to 4.
- m_data_ok pulse after reset with empty FIFO → no ch_data_ok; proto_err=1 and held until rst.
- Assert rst with 3 outstanding → next cycle outst_cnt=0, ch_data_ok=0, lock=0.
- With SRAMLIKE_ARB_RR_EN defined, both channels requesting continuously → grants alternate 0,1,0,1; accept count per channel differs by at most 1 over 20 cycles.
